id_capture: RTL and testbench

- Upstream stage of the access-check wrapper. Assembles the 32-bit dynamic ID from a byte stream that uses a valid/ready handshake.
- Checks an XOR checksum on each frame. Updates the held id_dynamic only when a frame is good.
- Flags checksum errors and inter-byte timeouts. The comparator and monitor downstream only ever see a stable, verified ID.

---
 rtl/id_capture_pkg.sv | 25 ++
 rtl/id_timeout_counter.sv | 32 +++
 rtl/id_capture.sv | 166 ++++++++++++++++
 tb/tb_id_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_capture_pkg.sv
// Shared types and constants for the dynamic-ID capture stage.
// Frames carry four ID bytes MSB-first followed by an XOR checksum byte.
package id_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int ID_BYTES    = 4;
    localparam int FRAME_BYTES = 5;
    localparam int ID_W        = 32;
    localparam int CNT_BITS    = 3;

    function automatic logic [7:0] xor_chk(input logic [ID_W-1:0] id);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < ID_BYTES; i++) begin
            r = r ^ id[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/id_timeout_counter.sv
// Inter-byte idle counter; pulses expire on the edge that would
// complete TIMEOUT_CYCLES consecutive idle cycles inside a frame.
module id_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = (r_cnt == LAST);
    assign expire = enable && !restart && w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!enable || restart || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/id_capture.sv
// Assembles a 32-bit ID from a valid/ready byte stream and publishes
// it only after the frame checksum verifies.
module id_capture
    import id_capture_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    input  logic            clear,
    output logic [ID_W-1:0] id_dynamic,
    output logic            id_valid,
    output logic            id_stable,
    output logic            err_checksum,
    output logic            err_timeout,
    output logic            busy
);

    state_t                r_state;
    state_t                w_state_nx;
    logic [ID_W-1:0]       r_shift;
    logic [ID_W-1:0]       w_shift_nx;
    logic [CNT_BITS-1:0]   r_count;
    logic [CNT_BITS-1:0]   w_count_nx;
    logic [7:0]            r_chk;
    logic [7:0]            w_chk_nx;
    logic [ID_W-1:0]       r_id;
    logic [ID_W-1:0]       w_id_nx;
    logic                  r_valid;
    logic                  w_valid_nx;
    logic                  r_stable;
    logic                  w_stable_nx;
    logic                  r_err_chk;
    logic                  w_err_chk_nx;
    logic                  r_err_to;
    logic                  w_err_to_nx;
    logic                  r_live;
    logic                  w_xfer;
    logic                  w_expire;
    logic                  w_recv;

    // Held low until the first edge after reset so no byte is taken early.
    assign byte_ready = r_live && !clear &&
                        (r_state == IDLE || r_state == RECV);
    assign w_xfer     = byte_valid && byte_ready;
    assign w_recv     = (r_state == RECV);

    id_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (w_recv),
        .restart(w_xfer || clear),
        .expire (w_expire)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_count_nx   = r_count;
        w_chk_nx     = r_chk;
        w_id_nx      = r_id;
        w_valid_nx   = 1'b0;
        w_stable_nx  = r_stable;
        w_err_chk_nx = r_err_chk;
        w_err_to_nx  = r_err_to;
        if (clear) begin
            w_state_nx   = IDLE;
            w_shift_nx   = '0;
            w_count_nx   = '0;
            w_chk_nx     = '0;
            w_id_nx      = '0;
            w_stable_nx  = 1'b0;
            w_err_chk_nx = 1'b0;
            w_err_to_nx  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        w_shift_nx = {{(ID_W-8){1'b0}}, byte_in};
                        w_count_nx = CNT_BITS'(1);
                        w_state_nx = RECV;
                    end
                end
                RECV: begin
                    if (w_xfer) begin
                        if (r_count == CNT_BITS'(ID_BYTES)) begin
                            w_chk_nx   = byte_in;
                            w_count_nx = CNT_BITS'(FRAME_BYTES);
                            w_state_nx = CHECK;
                        end else begin
                            w_shift_nx = {r_shift[ID_W-9:0], byte_in};
                            w_count_nx = r_count + 1'b1;
                        end
                    end else if (w_expire) begin
                        w_err_to_nx = 1'b1;
                        w_shift_nx  = '0;
                        w_count_nx  = '0;
                        w_state_nx  = IDLE;
                    end
                end
                CHECK: begin
                    if (xor_chk(r_shift) == r_chk) begin
                        w_id_nx     = r_shift;
                        w_valid_nx  = 1'b1;
                        w_stable_nx = 1'b1;
                    end else begin
                        w_err_chk_nx = 1'b1;
                    end
                    w_count_nx = '0;
                    w_state_nx = IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_count_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_count   <= '0;
            r_chk     <= '0;
            r_id      <= '0;
            r_valid   <= 1'b0;
            r_stable  <= 1'b0;
            r_err_chk <= 1'b0;
            r_err_to  <= 1'b0;
            r_live    <= 1'b0;
        end else begin
            r_shift   <= w_shift_nx;
            r_count   <= w_count_nx;
            r_chk     <= w_chk_nx;
            r_id      <= w_id_nx;
            r_valid   <= w_valid_nx;
            r_stable  <= w_stable_nx;
            r_err_chk <= w_err_chk_nx;
            r_err_to  <= w_err_to_nx;
            r_live    <= 1'b1;
        end
    end

    assign id_dynamic   = r_id;
    assign id_valid     = r_valid;
    assign id_stable    = r_stable;
    assign err_checksum = r_err_chk;
    assign err_timeout  = r_err_to;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_id_capture.sv
// Bench for id_capture: frame-level queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_capture;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        clear = 1'b0;
    logic        byte_ready;
    logic [31:0] id_dynamic;
    logic        id_valid;
    logic        id_stable;
    logic        err_checksum;
    logic        err_timeout;
    logic        busy;

    id_capture #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .clear       (clear),
        .id_dynamic  (id_dynamic),
        .id_valid    (id_valid),
        .id_stable   (id_stable),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes accepted so far in the current frame.
    logic [7:0]  m_q[$];
    bit          m_checking = 0;
    bit          m_live = 0;
    int          m_idle = 0;
    logic [31:0] m_id = '0;
    bit          m_valid = 0;
    bit          m_stable = 0;
    bit          m_echk = 0;
    bit          m_eto = 0;

    always @(posedge clk) begin
        bit         s_v;
        bit         s_c;
        bit         s_rdy;
        logic [7:0] s_b;
        logic [7:0] x;
        s_v = byte_valid;
        s_c = clear;
        s_b = byte_in;
        if (!rst) begin
            m_q.delete();
            m_checking = 0;
            m_live = 0;
            m_idle = 0;
            m_id = '0;
            m_valid = 0;
            m_stable = 0;
            m_echk = 0;
            m_eto = 0;
        end else begin
            s_rdy = m_live && !m_checking && !s_c;
            m_valid = 0;
            if (s_c) begin
                m_q.delete();
                m_checking = 0;
                m_idle = 0;
                m_id = '0;
                m_stable = 0;
                m_echk = 0;
                m_eto = 0;
            end else if (m_checking) begin
                x = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3];
                if (x == m_q[4]) begin
                    m_id = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    m_valid = 1;
                    m_stable = 1;
                end else begin
                    m_echk = 1;
                end
                m_q.delete();
                m_checking = 0;
            end else if (s_v && s_rdy) begin
                m_q.push_back(s_b);
                m_idle = 0;
                if (m_q.size() == 5) m_checking = 1;
            end else if (m_q.size() != 0) begin
                m_idle++;
                if (m_idle == T) begin
                    m_eto = 1;
                    m_q.delete();
                    m_idle = 0;
                end
            end
            m_live = 1;
        end
        #1;
        check("m_ready", byte_ready, rst && m_live && !m_checking && !clear);
        check("m_id", id_dynamic, m_id);
        check("m_valid", id_valid, m_valid);
        check("m_stable", id_stable, m_stable);
        check("m_echk", err_checksum, m_echk);
        check("m_eto", err_timeout, m_eto);
        check("m_busy", busy, m_q.size() != 0);
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_in = b;
        #1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready_wait", byte_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  stream[$];
        logic [31:0] rid;
        logic [7:0]  rchk;
        int          burst;
        burst = 0;

        repeat (3) @(negedge clk);
        check("rst_ready", byte_ready, 1'b0);
        check("rst_id", id_dynamic, 32'h0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", byte_ready, 1'b1);

        // Good frame, valid held across bytes.
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'hD5);
        byte_valid = 1'b0;
        check("good_check_ready", byte_ready, 1'b0);
        check("good_check_busy", busy, 1'b1);
        @(negedge clk);
        check("good_id", id_dynamic, 32'hA5123456);
        check("good_valid", id_valid, 1'b1);
        check("good_stable", id_stable, 1'b1);
        check("good_ready", byte_ready, 1'b1);
        @(negedge clk);
        check("good_valid_drop", id_valid, 1'b0);

        // Bad checksum (correct would be 44).
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h00);
        byte_valid = 1'b0;
        @(negedge clk);
        check("bad_echk", err_checksum, 1'b1);
        check("bad_id", id_dynamic, 32'hA5123456);
        check("bad_valid", id_valid, 1'b0);
        check("bad_stable", id_stable, 1'b1);

        // Inter-byte timeout.
        send_byte(8'h01);
        send_byte(8'h02);
        idle(T - 1);
        check("to_not_yet", err_timeout, 1'b0);
        check("to_busy_before", busy, 1'b1);
        @(negedge clk);
        check("to_set", err_timeout, 1'b1);
        check("to_busy_after", busy, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h04);
        idle(2);
        check("to_next_id", id_dynamic, 32'h01020304);
        check("to_sticky", err_timeout, 1'b1);

        // Clear mid-frame with a byte offered the same cycle.
        send_byte(8'hDE);
        send_byte(8'hAD);
        clear = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hBE;
        #1;
        check("clr_ready", byte_ready, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        byte_valid = 1'b0;
        check("clr_id", id_dynamic, 32'h0);
        check("clr_stable", id_stable, 1'b0);
        check("clr_flags", {err_checksum, err_timeout}, 2'b00);
        check("clr_busy", busy, 1'b0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
        idle(2);
        check("clr_next_id", id_dynamic, 32'h12345678);

        // Throttled source with short gaps.
        send_byte(8'hCA);
        idle(3);
        send_byte(8'hFE);
        idle(T - 2);
        send_byte(8'hBA);
        idle(1);
        send_byte(8'hBE);
        idle(5);
        send_byte(8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE);
        idle(1);
        check("thr_id", id_dynamic, 32'hCAFEBABE);
        check("thr_valid", id_valid, 1'b1);
        idle(1);
        check("thr_valid_once", id_valid, 1'b0);

        // Asynchronous reset mid-frame.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        byte_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_id", id_dynamic, 32'h0);
        check("arst_stable", id_stable, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", byte_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_byte(8'h04);
        send_byte(8'h05);
        idle(T + 2);
        check("arst_no_id", id_dynamic, 32'h0);
        check("arst_eto", err_timeout, 1'b1);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (stream.size() == 0) begin
                rid = $urandom;
                rchk = rid[31:24] ^ rid[23:16] ^ rid[15:8] ^ rid[7:0];
                if ($urandom_range(0, 3) == 0) rchk = rchk ^ 8'($urandom_range(1, 255));
                stream.push_back(rid[31:24]);
                stream.push_back(rid[23:16]);
                stream.push_back(rid[15:8]);
                stream.push_back(rid[7:0]);
                stream.push_back(rchk);
            end
            if (burst > 0) begin
                byte_valid = 1'b0;
                burst--;
            end else begin
                byte_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) burst = T + $urandom_range(0, 3);
            end
            clear = ($urandom_range(0, 79) == 0);
            byte_in = stream[0];
            #1;
            if (byte_valid && byte_ready) void'(stream.pop_front());
            @(negedge clk);
        end
        clear = 1'b0;
        idle(T + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
